// File: rtl/modular_multiplier_arbiter_pkg.sv
// Shared widths and defaults for the modular-multiplier arbiter slice.
// Instances override the parameter defaults where a different multiplier is attached.
package mm_pkg;

    localparam int MM_DATA_W      = 30;
    localparam int MM_PROD_W      = 2 * MM_DATA_W;
    localparam int MM_MUL_LATENCY = 1;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/modular_multiplier_arbiter_if.sv
// Requester-side bus of the multiplier arbiter: packed operand request lanes,
// the per-requester grant, the one-hot result strobe and the shared busy flag.
interface modular_multiplier_arbiter_if
    import mm_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = MM_DATA_W
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [2*DATA_W-1:0]       resp_data;
    logic                      busy;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, resp_valid, resp_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, resp_valid, resp_data, busy
    );

endinterface

// File: rtl/modular_multiplier_arbiter_rr_arbiter.sv
// Combinational round-robin grant: scans from ptr upward, wrapping at
// NUM_REQ-1, and returns a one-hot grant for the first active request.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic found;
    int   idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx[IDX_W-1:0]]) begin
                grant[idx[IDX_W-1:0]] = 1'b1;
                found                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/modular_multiplier_arbiter.sv
// Shares one external pipelined multiplier among NUM_REQ requesters: round-robin
// operand grant, registered operands, and a tag pipeline that routes results back.
module modular_multiplier_arbiter
    import mm_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = MM_MUL_LATENCY,
    parameter int DATA_W      = MM_DATA_W
) (
    input  logic                         clk,
    input  logic                         rst,
    modular_multiplier_arbiter_if.slave  bus,
    output logic [DATA_W-1:0]            mul_a,
    output logic [DATA_W-1:0]            mul_b,
    input  logic [2*DATA_W-1:0]          mul_c
);

    localparam int IDX_W  = idx_w(NUM_REQ);
    localparam int PROD_W = 2 * DATA_W;
    localparam int DEPTH  = MUL_LATENCY + 1;

    logic [IDX_W-1:0]   ptr;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] ready;
    logic               transfer;
    logic [IDX_W-1:0]   gidx;
    logic [DATA_W-1:0]  sel_a;
    logic [DATA_W-1:0]  sel_b;

    logic [DEPTH-1:0]   tag_v;
    logic [IDX_W-1:0]   tag_idx [DEPTH];
    logic [NUM_REQ-1:0] resp_valid_q;
    logic [PROD_W-1:0]  resp_data_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    // Grant is suppressed during reset so nothing can transfer on a reset edge.
    assign ready    = rst ? '0 : grant;
    assign transfer = |ready;

    always_comb begin
        gidx  = '0;
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gidx  = IDX_W'(i);
                sel_a = bus.req_a[i*DATA_W +: DATA_W];
                sel_b = bus.req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr          <= '0;
            mul_a        <= '0;
            mul_b        <= '0;
            tag_v        <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                tag_idx[j] <= '0;
            end
        end else begin
            if (transfer) begin
                ptr   <= (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                mul_a <= sel_a;
                mul_b <= sel_b;
            end else begin
                mul_a <= '0;
                mul_b <= '0;
            end

            // Stage 0 lines up with mul_a/mul_b; the last stage lines up with mul_c.
            tag_v[0]   <= transfer;
            tag_idx[0] <= gidx;
            for (int j = 1; j < DEPTH; j++) begin
                tag_v[j]   <= tag_v[j-1];
                tag_idx[j] <= tag_idx[j-1];
            end

            if (tag_v[DEPTH-1]) begin
                resp_valid_q <= NUM_REQ'(1) << tag_idx[DEPTH-1];
                resp_data_q  <= mul_c;
            end else begin
                resp_valid_q <= '0;
                resp_data_q  <= '0;
            end
        end
    end

    assign bus.req_ready  = ready;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.busy       = (|tag_v) | (|resp_valid_q);

endmodule

// File: tb/tb_modular_multiplier_arbiter.sv
// Scoreboard bench for modular_multiplier_arbiter with a behavioural pipelined
// multiplier; a round-robin reference model predicts grants and result timing.
module tb_modular_multiplier_arbiter;
    import mm_pkg::*;

    localparam int NUM_REQ     = 4;
    localparam int MUL_LATENCY = 1;
    localparam int DATA_W      = 30;
    localparam int PROD_W      = 2 * DATA_W;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } op_t;

    typedef struct {
        int                idx;
        int                due;
        logic [PROD_W-1:0] prod;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] mul_a;
    logic [DATA_W-1:0] mul_b;
    logic [PROD_W-1:0] mul_c;
    logic [PROD_W-1:0] prod_pipe [MUL_LATENCY];

    op_t               pend [NUM_REQ][$];
    exp_t              sb [$];
    int                glog [$];
    int                gcyc [$];
    logic [PROD_W-1:0] rlog [$];
    int                rcyc [$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int mptr = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    modular_multiplier_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    modular_multiplier_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .MUL_LATENCY (MUL_LATENCY),
        .DATA_W      (DATA_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .mul_a (mul_a),
        .mul_b (mul_b),
        .mul_c (mul_c)
    );

    always @(posedge clk) begin
        prod_pipe[0] <= PROD_W'(mul_a) * PROD_W'(mul_b);
        for (int j = 1; j < MUL_LATENCY; j++) prod_pipe[j] <= prod_pipe[j-1];
    end
    assign mul_c = prod_pipe[MUL_LATENCY-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pend_total();
        int t = 0;
        for (int i = 0; i < NUM_REQ; i++) t += pend[i].size();
        return t;
    endfunction

    // Per-cycle check of busy, results and grant, then model update.
    task automatic monitor_cycle();
        logic [NUM_REQ-1:0] g;
        int                 gi;
        int                 i;
        exp_t               e;
        op_t                o;
        check_eq("busy", bus.busy, sb.size() > 0);
        if (bus.resp_valid != '0) begin
            rlog.push_back(bus.resp_data);
            rcyc.push_back(cyc);
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check_eq("resp_valid", bus.resp_valid, 64'(1) << e.idx);
            check_eq("resp_data", bus.resp_data, e.prod);
        end else begin
            check_eq("resp_idle_valid", bus.resp_valid, 0);
            check_eq("resp_idle_data", bus.resp_data, 0);
        end
        if (rst) begin
            sb.delete();
            mptr = 0;
            check_eq("ready_in_rst", bus.req_ready, 0);
        end else begin
            g  = '0;
            gi = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                i = (mptr + k) % NUM_REQ;
                if (gi < 0 && bus.req_valid[i]) gi = i;
            end
            if (gi >= 0) g[gi] = 1'b1;
            check_eq("req_ready", bus.req_ready, g);
            if (gi >= 0 && pend[gi].size() > 0) begin
                o = pend[gi].pop_front();
                sb.push_back('{idx: gi, due: cyc + MUL_LATENCY + 2,
                               prod: PROD_W'(o.a) * PROD_W'(o.b)});
                glog.push_back(gi);
                gcyc.push_back(cyc);
                mptr = (gi + 1) % NUM_REQ;
            end
        end
    endtask

    always @(negedge clk) if (mon_en) monitor_cycle();

    task automatic step();
        logic [NUM_REQ-1:0]        v;
        logic [NUM_REQ*DATA_W-1:0] a;
        logic [NUM_REQ*DATA_W-1:0] b;
        @(posedge clk);
        #1;
        v = '0;
        a = '0;
        b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pend[i].size() > 0) begin
                v[i]                  = 1'b1;
                a[i*DATA_W +: DATA_W] = pend[i][0].a;
                b[i*DATA_W +: DATA_W] = pend[i][0].b;
            end
        end
        bus.req_valid = v;
        bus.req_a     = a;
        bus.req_b     = b;
    endtask

    task automatic drain(input string tag, input int max_cyc);
        int n = 0;
        while ((sb.size() > 0 || pend_total() > 0) && n < max_cyc) begin
            step();
            n++;
        end
        check_eq(tag, (sb.size() == 0 && pend_total() == 0), 1);
        step();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        glog.delete();
        gcyc.delete();
        rlog.delete();
        rcyc.delete();
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        check_eq("rst_ready", bus.req_ready, 0);
        check_eq("rst_mul_a", mul_a, 0);
        check_eq("rst_mul_b", mul_b, 0);
        check_eq("rst_resp_valid", bus.resp_valid, 0);
        check_eq("rst_resp_data", bus.resp_data, 0);
        check_eq("rst_busy", bus.busy, 0);
        step();
        rst = 1'b0;

        // Single request on requester 0
        clear_logs();
        pend[0].push_back('{a: 30'd10, b: 30'd10});
        drain("s1_drain", 20);
        check_eq("s1_grants", glog.size(), 1);
        check_eq("s1_resps", rlog.size(), 1);
        if (rlog.size() == 1 && gcyc.size() == 1) begin
            check_eq("s1_data", rlog[0], 100);
            check_eq("s1_latency", rcyc[0] - gcyc[0], 3);
        end

        // All four requesters at once
        apply_reset();
        clear_logs();
        pend[0].push_back('{a: 30'd5,  b: 30'd5});
        pend[1].push_back('{a: 30'd90, b: 30'd30});
        pend[2].push_back('{a: 30'd40, b: 30'd23});
        pend[3].push_back('{a: 30'd0,  b: 30'd10000});
        drain("s2_drain", 30);
        check_eq("s2_grants", glog.size(), 4);
        check_eq("s2_resps", rlog.size(), 4);
        if (glog.size() == 4 && rlog.size() == 4) begin
            for (int i = 0; i < 4; i++) check_eq("s2_order", glog[i], i);
            check_eq("s2_r0", rlog[0], 25);
            check_eq("s2_r1", rlog[1], 2700);
            check_eq("s2_r2", rlog[2], 920);
            check_eq("s2_r3", rlog[3], 0);
            check_eq("s2_span", gcyc[3] - gcyc[0], 3);
        end

        // Requesters 0 and 2 continuously valid
        apply_reset();
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            pend[0].push_back('{a: DATA_W'($urandom()), b: DATA_W'($urandom())});
            pend[2].push_back('{a: DATA_W'($urandom()), b: DATA_W'($urandom())});
        end
        drain("s3_drain", 40);
        check_eq("s3_grants", glog.size(), 8);
        if (glog.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check_eq("s3_alternate", glog[i], (i % 2 == 0) ? 0 : 2);
                if (i > 0) check_eq("s3_gap", gcyc[i] - gcyc[i-1], 1);
            end
        end

        // Requester 3 alone, back-to-back
        apply_reset();
        clear_logs();
        pend[3].push_back('{a: 30'd123456, b: 30'd7891234});
        for (int i = 0; i < 3; i++)
            pend[3].push_back('{a: DATA_W'($urandom()), b: DATA_W'($urandom())});
        drain("s4_drain", 30);
        check_eq("s4_grants", glog.size(), 4);
        check_eq("s4_resps", rlog.size(), 4);
        if (glog.size() == 4 && rlog.size() == 4) begin
            check_eq("s4_first", rlog[0], 60'd974220184704);
            for (int i = 0; i < 4; i++) check_eq("s4_idx", glog[i], 3);
            for (int i = 1; i < 4; i++) check_eq("s4_b2b", gcyc[i] - gcyc[i-1], 1);
        end

        // Reset one cycle after a transfer discards it
        apply_reset();
        clear_logs();
        pend[1].push_back('{a: 30'd7, b: 30'd9});
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (5) step();
        check_eq("s5_killed_grant", glog.size(), 1);
        check_eq("s5_no_resp", rlog.size(), 0);
        check_eq("s5_busy", bus.busy, 0);
        clear_logs();
        pend[1].push_back('{a: 30'd11, b: 30'd12});
        pend[3].push_back('{a: 30'd13, b: 30'd14});
        drain("s5_drain", 30);
        check_eq("s5_grants", glog.size(), 2);
        if (glog.size() == 2) begin
            check_eq("s5_first_after_rst", glog[0], 1);
            check_eq("s5_second", glog[1], 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/modular_multiplier_arbiter.md
MODULAR_MULTIPLIER_ARBITER -- requirements
Module: modular_multiplier_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one modular_multiplier.
REQ-002 Parameter MUL_LATENCY, default 1: clock cycles from mul_a/mul_b presented to mul_c valid.
REQ-003 Parameter DATA_W, default 30: operand width; product width is 2*DATA_W (60).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  NUM_REQ  per-requester operand-valid.
REQ-007 req_ready  out  NUM_REQ  per-requester grant; one-hot or zero.
REQ-008 req_a, req_b  in  NUM_REQ*DATA_W each  packed operands; requester i uses bits [i*DATA_W +: DATA_W].
REQ-009 mul_a, mul_b  out  DATA_W each  registered operands to the multiplier.
REQ-010 mul_c  in  2*DATA_W  multiplier result.
REQ-011 resp_valid  out  NUM_REQ  one-hot result strobe, one cycle per accepted request.
REQ-012 resp_data  out  2*DATA_W  result for the requester flagged in resp_valid.
REQ-013 busy  out  1  high while any accepted request has not yet been returned.

Function
REQ-014 Handshake: transfer on requester i when req_valid[i] && req_ready[i] at a rising edge; at most one transfer per cycle.
REQ-015 req_ready is combinational from req_valid and the priority pointer; req_ready[i] is never high while req_valid[i] is low.
REQ-016 Arbitration is round-robin: search starts at index ptr, wraps NUM_REQ-1 -> 0, grants the first valid requester.
REQ-017 ptr becomes (granted index + 1) mod NUM_REQ on a transfer; holds otherwise.
REQ-018 A requester holding req_valid is granted within NUM_REQ cycles (no starvation).
REQ-019 On transfer, mul_a/mul_b register the granted operands at that edge; when no transfer occurs they register 0.
REQ-020 A tag pipeline of depth MUL_LATENCY+1 carries {valid, requester index} alongside the operands.
REQ-021 resp_valid/resp_data are registered: a transfer at edge k yields resp_valid one-hot at the requester's index in the cycle following edge k+MUL_LATENCY+1, with resp_data = mul_c captured at that edge.
REQ-022 Throughput is one transfer per cycle; responses return in issue order; no response backpressure, so requesters accept results unconditionally.
REQ-023 resp_data is 0 in any cycle where resp_valid is all-zero.
REQ-024 busy = OR of all tag-pipeline valid bits and the resp_valid register.
REQ-025 Operands are passed through unaltered; no arithmetic is performed on mul_c.

Reset
REQ-026 While rst is high at an edge: req_ready all-zero, no transfer, ptr = 0, all tag valids = 0, mul_a = mul_b = 0, resp_valid = 0, resp_data = 0, busy = 0.
REQ-027 rst mid-operation discards all in-flight requests; no resp_valid is produced for them after rst deasserts.
REQ-028 First grant after reset goes to the lowest-indexed valid requester.

Structure
REQ-029 Shared package mm_pkg holds DATA_W, PROD_W = 2*DATA_W, and the default MUL_LATENCY.
REQ-030 Round-robin grant logic is a sub-module rr_arbiter (inputs req, ptr; output one-hot grant).
REQ-031 The modular_multiplier is instantiated outside this block and connected via mul_a/mul_b/mul_c.

Verification
REQ-032 The bench uses a behavioural multiplier returning the full 60-bit a*b after MUL_LATENCY cycles; all scenarios use MUL_LATENCY=1.
REQ-033 Single request: req_valid[0] with a=10, b=10 at cycle 0 -> resp_valid=4'b0001, resp_data=100 in cycle 3; busy high in cycles 1-3.
REQ-034 All four requesters valid at cycle 0 after reset, with operands (5,5), (90,30), (40,23), (0,10000) -> grants 0,1,2,3 in cycles 0-3; responses 25, 2700, 920, 0 in cycles 3-6.
REQ-035 Requesters 0 and 2 held valid continuously -> grants alternate 0,2,0,2; neither waits more than one cycle.
REQ-036 Requester 3 alone, back-to-back for 4 cycles, first operands a=123456, b=7891234 -> one transfer per cycle; first response 974220184704.
REQ-037 rst pulsed one cycle after a transfer -> no resp_valid for that transfer; ptr=0 and busy=0 afterwards.
